// File: rtl/led_pwm_pkg.sv
// Shared register-map constants and CTRL layout for the Avalon LED PWM driver.
package led_pwm_pkg;

    localparam int ADDR_CTRL         = 0;
    localparam int ADDR_PRESCALE     = 1;
    localparam int ADDR_BLINK_MASK   = 2;
    localparam int ADDR_BLINK_PERIOD = 3;
    localparam int ADDR_DUTY_BASE    = 4;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_INV = 1;

    typedef struct packed {
        logic inv;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/avalon_led_pwm_if.sv
// Avalon-MM s1 slave bundle for the LED PWM driver (16-bit data, no waitrequest).
interface avalon_led_pwm_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] avs_s1_address;
    logic              avs_s1_write;
    logic [15:0]       avs_s1_writedata;
    logic              avs_s1_read;
    logic [15:0]       avs_s1_readdata;

    modport master (
        output avs_s1_address, avs_s1_write, avs_s1_writedata, avs_s1_read,
        input  avs_s1_readdata
    );

    modport slave (
        input  avs_s1_address, avs_s1_write, avs_s1_writedata, avs_s1_read,
        output avs_s1_readdata
    );
endinterface

// File: rtl/led_pwm_channel.sv
// One LED channel: duty compare, blink gating, enable/invert, registered pin drive.
module led_pwm_channel #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] duty,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                mask,
    input  logic                blink_phase,
    input  logic                en,
    input  logic                inv,
    output logic                led
);

    logic on_p0;
    logic g_p0;

    // all-ones duty is forced solid on; otherwise the top count value would be dark
    assign on_p0 = (&duty) || (pwm_cnt < duty);
    assign g_p0  = en && on_p0 && !(mask && !blink_phase);

    // stage p0 -> p1: registered LED pin
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led <= 1'b0;
        end else begin
            led <= g_p0 ^ inv;
        end
    end

endmodule

// File: rtl/avalon_led_pwm.sv
// CHANNELS-wide PWM LED driver on Avalon-MM; register file, prescaler, PWM and blink counters.
// Readback of registers is built only when LED_PWM_READBACK_EN is defined.
module avalon_led_pwm
    import led_pwm_pkg::*;
#(
    parameter int CHANNELS   = 8,
    parameter int PWM_BITS   = 8,
    parameter int PRESCALE_W = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                 csi_clk,
    input  logic                 csi_reset,
    avalon_led_pwm_if.slave      avs,
    output logic [CHANNELS-1:0]  coe_led
);

    ctrl_t                  ctrl;
    logic [PRESCALE_W-1:0]  prescale;
    logic [CHANNELS-1:0]    blink_mask;
    logic [7:0]             blink_period;
    logic [PWM_BITS-1:0]    duty [CHANNELS];

    logic [PRESCALE_W-1:0]  pre_cnt;
    logic [PWM_BITS-1:0]    pwm_cnt;
    logic [7:0]             blk_cnt;
    logic                   blink_phase;

    logic wr_ctrl, wr_prescale, wr_mask, wr_period;
    logic tick, wrap;

    assign wr_ctrl     = avs.avs_s1_write && (avs.avs_s1_address == ADDR_W'(ADDR_CTRL));
    assign wr_prescale = avs.avs_s1_write && (avs.avs_s1_address == ADDR_W'(ADDR_PRESCALE));
    assign wr_mask     = avs.avs_s1_write && (avs.avs_s1_address == ADDR_W'(ADDR_BLINK_MASK));
    assign wr_period   = avs.avs_s1_write && (avs.avs_s1_address == ADDR_W'(ADDR_BLINK_PERIOD));

    always_ff @(posedge csi_clk or posedge csi_reset) begin
        if (csi_reset) begin
            ctrl         <= '0;
            prescale     <= '0;
            blink_mask   <= '0;
            blink_period <= '0;
            for (int i = 0; i < CHANNELS; i++) duty[i] <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl <= '{inv: avs.avs_s1_writedata[CTRL_INV], en: avs.avs_s1_writedata[CTRL_EN]};
            end
            if (wr_prescale) prescale     <= avs.avs_s1_writedata[PRESCALE_W-1:0];
            if (wr_mask)     blink_mask   <= avs.avs_s1_writedata[CHANNELS-1:0];
            if (wr_period)   blink_period <= avs.avs_s1_writedata[7:0];
            for (int i = 0; i < CHANNELS; i++) begin
                if (avs.avs_s1_write && (avs.avs_s1_address == ADDR_W'(ADDR_DUTY_BASE + i))) begin
                    duty[i] <= avs.avs_s1_writedata[PWM_BITS-1:0];
                end
            end
        end
    end

    // a PRESCALE write restarts the prescaler and swallows any tick on that edge
    assign tick = ctrl.en && !wr_prescale && (pre_cnt == prescale);
    assign wrap = tick && (&pwm_cnt);

    always_ff @(posedge csi_clk or posedge csi_reset) begin
        if (csi_reset) begin
            pre_cnt     <= '0;
            pwm_cnt     <= '0;
            blk_cnt     <= '0;
            blink_phase <= 1'b0;
        end else if (!ctrl.en) begin
            pre_cnt     <= '0;
            pwm_cnt     <= '0;
            blk_cnt     <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (wr_prescale || tick) pre_cnt <= '0;
            else                     pre_cnt <= pre_cnt + 1'b1;
            if (tick) pwm_cnt <= pwm_cnt + 1'b1;
            if (wrap) begin
                if (blk_cnt == blink_period) begin
                    blk_cnt     <= '0;
                    blink_phase <= !blink_phase;
                end else begin
                    blk_cnt <= blk_cnt + 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        led_pwm_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clk         (csi_clk),
            .rst         (csi_reset),
            .duty        (duty[i]),
            .pwm_cnt     (pwm_cnt),
            .mask        (blink_mask[i]),
            .blink_phase (blink_phase),
            .en          (ctrl.en),
            .inv         (ctrl.inv),
            .led         (coe_led[i])
        );
    end

`ifdef LED_PWM_READBACK_EN
    logic [15:0] rd_mux;
    logic        unused_bits;

    always_comb begin
        rd_mux = '0;
        if (avs.avs_s1_address == ADDR_W'(ADDR_CTRL))         rd_mux = {14'd0, ctrl.inv, ctrl.en};
        if (avs.avs_s1_address == ADDR_W'(ADDR_PRESCALE))     rd_mux = 16'(prescale);
        if (avs.avs_s1_address == ADDR_W'(ADDR_BLINK_MASK))   rd_mux = 16'(blink_mask);
        if (avs.avs_s1_address == ADDR_W'(ADDR_BLINK_PERIOD)) rd_mux = {8'd0, blink_period};
        for (int i = 0; i < CHANNELS; i++) begin
            if (avs.avs_s1_address == ADDR_W'(ADDR_DUTY_BASE + i)) rd_mux = 16'(duty[i]);
        end
    end

    always_ff @(posedge csi_clk or posedge csi_reset) begin
        if (csi_reset) begin
            avs.avs_s1_readdata <= '0;
        end else if (avs.avs_s1_read) begin
            avs.avs_s1_readdata <= rd_mux;
        end
    end

    assign unused_bits = ^avs.avs_s1_writedata;
`else
    logic unused_bits;

    assign avs.avs_s1_readdata = 16'h0000;
    assign unused_bits         = ^{avs.avs_s1_writedata, avs.avs_s1_read};
`endif

endmodule

// File: doc/avalon_led_pwm.md
Name: avalon_led_pwm

Overview:
- Parametrised successor to the single-register LED output port: a CHANNELS-wide LED driver on an Avalon-MM slave.
- Each channel has a per-channel PWM brightness and an optional shared blink gate.
- Registered outputs drive the board LED pins (coe_led) directly.
- Sits in the SOPC/Qsys system as a memory-mapped peripheral beside the other board I/O blocks.

Parameters:
- CHANNELS, 8, number of LED outputs (1..12).
- PWM_BITS, 8, duty/PWM counter width.
- PRESCALE_W, 16, prescaler register width (PRESCALE_W <= 16).
- ADDR_W, 4, Avalon word address width; 4+CHANNELS <= 2**ADDR_W.

Ports:
- csi_clk  in  1  system clock.
- csi_reset  in  1  asynchronous active-high reset.
- avs_s1_address  in  ADDR_W  word address.
- avs_s1_write  in  1  write strobe.
- avs_s1_writedata  in  16  write data.
- avs_s1_read  in  1  read strobe.
- avs_s1_readdata  out  16  read data, one-cycle latency.
- coe_led  out  CHANNELS  LED drive, bit i = channel i.

Behaviour:
- Reset: one clock (csi_clk); reset csi_reset is asynchronous and active-high. While asserted or after release: all registers 0, all counters 0, blink_phase 0, coe_led 0, avs_s1_readdata 0. Reset mid-PWM-period clears everything immediately, with no glitch-filtering.
- Register map (word addresses):
  - 0 CTRL: bit0 EN, bit1 INV.
  - 1 PRESCALE[PRESCALE_W-1:0].
  - 2 BLINK_MASK[CHANNELS-1:0].
  - 3 BLINK_PERIOD[7:0].
  - 4+i DUTY_i[PWM_BITS-1:0].
  - Unused writedata bits are ignored; writes to unmapped addresses are ignored.
- Writes take effect on the clock edge where avs_s1_write=1. There is no waitrequest.
- Prescaler: pre_cnt counts 0..PRESCALE. tick=1 when pre_cnt==PRESCALE, then pre_cnt wraps to 0. PRESCALE=0 gives tick every cycle. A write to PRESCALE clears pre_cnt in the same edge, and the write wins over a coincident tick.
- PWM counter: pwm_cnt (PWM_BITS) increments on tick and wraps all-ones -> 0. wrap = tick && pwm_cnt==all-ones.
- Blink:
  - blk_cnt (8b) increments on wrap.
  - When blk_cnt==BLINK_PERIOD at a wrap, blk_cnt -> 0 and blink_phase toggles.
  - BLINK_PERIOD=0 toggles on every wrap.
- Per-channel raw output: on_i = (DUTY_i==all-ones) ? 1 : (pwm_cnt < DUTY_i).
  - DUTY=0 is always off.
  - DUTY=all-ones is solid on.
- Gating: g_i = on_i && !(BLINK_MASK[i] && !blink_phase).
- EN=0: pre_cnt, pwm_cnt, blk_cnt, blink_phase held at 0 and g_i=0. Registers remain writable.
- Output: coe_led[i] <= g_i ^ INV, registered, so it lags the counter state by one cycle. With EN=0 and INV=1, all outputs are 1.
- DUTY write mid-period: the new value is compared from the next cycle; no period alignment.
- Read: when avs_s1_read=1, avs_s1_readdata on the next edge = addressed register, zero-extended. Unmapped addresses read 0. avs_s1_readdata holds its value otherwise.

Optional Feature:
- Macro LED_PWM_READBACK_EN.
- Defined: read path as above.
- Undefined: the read path is not built; avs_s1_readdata is tied to 16'h0000 and avs_s1_read is ignored. Ports remain so the system integration is unchanged.

Decomposition:
- Package led_pwm_pkg holds:
  - address constants ADDR_CTRL=0, ADDR_PRESCALE=1, ADDR_BLINK_MASK=2, ADDR_BLINK_PERIOD=3, ADDR_DUTY_BASE=4;
  - CTRL bit indices CTRL_EN=0, CTRL_INV=1.
- Sub-module led_pwm_channel, one instance per channel via generate. It takes duty, pwm_cnt, mask bit, blink_phase, EN and INV, and produces the registered coe_led bit.
- Top keeps the register file, prescaler, PWM counter and blink counter.

Test Plan:
- Reset/defaults: assert csi_reset mid-run with outputs toggling -> coe_led=0 immediately; all registers read back 0 after release.
- Duty ratio: CTRL=1, PRESCALE=0, DUTY_0=64, DUTY_1=0, DUTY_2=255 -> over 256 cycles ch0 high exactly 64 cycles, ch1 never, ch2 always.
- Prescaler: PRESCALE=3, DUTY_0=2 -> ch0 high 8 of every 1024 cycles. Rewriting PRESCALE mid-count restarts pre_cnt at 0.
- Blink: BLINK_MASK=0x01, BLINK_PERIOD=1, DUTY_0=255, PRESCALE=0 -> ch0 off 512 cycles, on 512 cycles, repeating; unmasked ch1 unaffected.
- Invert/enable: CTRL=2 (EN=0, INV=1) -> coe_led=all-ones, counters frozen. Then CTRL=3 -> PWM resumes from pwm_cnt=0 with inverted output.
- Readback (LED_PWM_READBACK_EN): write DUTY_3=0xA5, read addr 7 -> readdata=0x00A5 one cycle after read. Read addr 15 -> 0. Without the macro, readdata stays 0.
